// File: rtl/mul_pkg.sv
// mul_pkg: shared multiplier widths and the pipeline-stage valid state
package mul_pkg;

    localparam int DEF_NUM_PP = 13;
    localparam int DEF_PP_W   = 26;
    localparam int DEF_OP_W   = 32;
    localparam int PP_BUS_W   = DEF_NUM_PP * DEF_PP_W;

    // Encoding doubles as the occupancy count; bit 1 alone marks FULL.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

endpackage

// File: rtl/mul_stage_reg_if.sv
// mul_stage_reg_if: upstream/downstream handshake and data bundle for the stage
interface mul_stage_reg_if
    import mul_pkg::*;
#(
    parameter int NUM_PP = DEF_NUM_PP,
    parameter int PP_W   = DEF_PP_W,
    parameter int OP_W   = DEF_OP_W
);

    logic                   flush;
    logic                   in_valid;
    logic                   in_ready;
    logic [NUM_PP*PP_W-1:0] in_pp;
    logic [OP_W-1:0]        in_a;
    logic [OP_W-1:0]        in_b;
    logic                   out_valid;
    logic                   out_ready;
    logic [NUM_PP*PP_W-1:0] out_pp;
    logic [OP_W-1:0]        out_a;
    logic [OP_W-1:0]        out_b;
    logic [1:0]             occupancy;

    modport master (
        output flush, in_valid, in_pp, in_a, in_b, out_ready,
        input  in_ready, out_valid, out_pp, out_a, out_b, occupancy
    );

    modport slave (
        input  flush, in_valid, in_pp, in_a, in_b, out_ready,
        output in_ready, out_valid, out_pp, out_a, out_b, occupancy
    );

endinterface

// File: rtl/mul_entry_reg.sv
// mul_entry_reg: one load-enabled entry register with synchronous clear
module mul_entry_reg #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         ld_i,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);

    logic [W-1:0] data_q;

    // Hold unless loaded so idle cycles cause no toggling.
    always_ff @(posedge clk) begin
        if (rst) data_q <= '0;
        else if (ld_i) data_q <= d_i;
    end

    assign q_o = data_q;

endmodule

// File: rtl/mul_stage_reg.sv
// mul_stage_reg: two-entry skid-buffered register slice for partial products
module mul_stage_reg
    import mul_pkg::*;
#(
    parameter int NUM_PP = DEF_NUM_PP,
    parameter int PP_W   = DEF_PP_W,
    parameter int OP_W   = DEF_OP_W
) (
    input logic            clk,
    input logic            rst,
    mul_stage_reg_if.slave bus
);

    localparam int EW = NUM_PP * PP_W + 2 * OP_W;

    state_t          state_q, state_d;
    logic            in_xfer, main_ld_d, skid_ld_d;
    logic [EW-1:0]   in_e, main_d, main_q, skid_q;

    assign in_e = {bus.in_pp, bus.in_a, bus.in_b};

    // Decide where an accepted entry lands and how the valid state moves.
    always_comb begin
        state_d   = state_q;
        main_ld_d = 1'b0;
        skid_ld_d = 1'b0;
        main_d    = in_e;
        in_xfer   = bus.in_valid & ~state_q[1];
        case (state_q)
            EMPTY: begin
                main_ld_d = in_xfer;
                state_d   = in_xfer ? ONE : EMPTY;
            end
            ONE: begin
                main_ld_d = in_xfer & bus.out_ready;
                skid_ld_d = in_xfer & ~bus.out_ready;
                state_d   = (in_xfer & ~bus.out_ready) ? FULL :
                            (~in_xfer & bus.out_ready) ? EMPTY : ONE;
            end
            FULL: begin
                main_ld_d = bus.out_ready;
                main_d    = skid_q;
                state_d   = bus.out_ready ? ONE : FULL;
            end
            default: state_d = EMPTY;
        endcase
        if (bus.flush) begin
            state_d   = EMPTY;
            main_ld_d = 1'b0;
            skid_ld_d = 1'b0;
        end
    end

    // Valid state register; reset outranks flush, which is folded into state_d.
    always_ff @(posedge clk) begin
        if (rst) state_q <= EMPTY;
        else state_q <= state_d;
    end

    mul_entry_reg #(.W(EW)) u_main (
        .clk  (clk),
        .rst  (rst),
        .ld_i (main_ld_d),
        .d_i  (main_d),
        .q_o  (main_q)
    );

    mul_entry_reg #(.W(EW)) u_skid (
        .clk  (clk),
        .rst  (rst),
        .ld_i (skid_ld_d),
        .d_i  (in_e),
        .q_o  (skid_q)
    );

    assign bus.in_ready  = ~state_q[1];
    assign bus.out_valid = |state_q;
    assign bus.occupancy = state_q;
    assign {bus.out_pp, bus.out_a, bus.out_b} = main_q;

endmodule

// File: tb/tb_mul_stage_reg.sv
// tb_mul_stage_reg: directed and randomized checks of the skid-buffered stage
module tb_mul_stage_reg;

    localparam int BP = 13, BW = 26, BO = 32;
    localparam int SP = 4,  SW = 8,  SO = 16;
    localparam int BE = BP * BW + 2 * BO;
    localparam int SE = SP * SW + 2 * SO;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   tests = 0;
    int   fails = 0;

    always #5 clk = ~clk;

    mul_stage_reg_if #(.NUM_PP(BP), .PP_W(BW), .OP_W(BO)) bb ();
    mul_stage_reg_if #(.NUM_PP(SP), .PP_W(SW), .OP_W(SO)) sb ();

    mul_stage_reg #(.NUM_PP(BP), .PP_W(BW), .OP_W(BO)) u_big (
        .clk (clk),
        .rst (rst),
        .bus (bb.slave)
    );

    mul_stage_reg #(.NUM_PP(SP), .PP_W(SW), .OP_W(SO)) u_small (
        .clk (clk),
        .rst (rst),
        .bus (sb.slave)
    );

    function automatic logic [BE-1:0] rand_big();
        logic [BE-1:0] r;
        for (int i = 0; i < BP; i++) r[2*BO + i*BW +: BW] = BW'($urandom);
        r[2*BO-1:0] = {$urandom, $urandom};
        return r;
    endfunction

    function automatic logic [BE-1:0] big_out();
        return {bb.out_pp, bb.out_a, bb.out_b};
    endfunction

    function automatic logic [SE-1:0] small_out();
        return {sb.out_pp, sb.out_a, sb.out_b};
    endfunction

    task automatic drive_big(input logic v, input logic [BE-1:0] e);
        bb.in_valid = v;
        {bb.in_pp, bb.in_a, bb.in_b} = e;
    endtask

    task automatic test_reset();
        tests++; if (bb.out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid: got %b want 0", bb.out_valid); end
        tests++; if (bb.in_ready !== 1'b1) begin fails++; $display("FAIL reset_in_ready: got %b want 1", bb.in_ready); end
        tests++; if (bb.occupancy !== 2'd0) begin fails++; $display("FAIL reset_occupancy: got %0d want 0", bb.occupancy); end
        tests++; if (big_out() !== '0) begin fails++; $display("FAIL reset_data: got %h want 0", big_out()); end
        tests++; if (sb.out_valid !== 1'b0) begin fails++; $display("FAIL reset_small_valid: got %b want 0", sb.out_valid); end
    endtask

    task automatic test_single();
        logic [BE-1:0] e = '0;
        e[2*BO +: BW]  = 26'h1;
        e[2*BO-1:BO]   = 32'h3F800000;
        e[BO-1:0]      = 32'h40000000;
        bb.out_ready = 1'b1;
        tests++; if (bb.occupancy !== 2'd0) begin fails++; $display("FAIL single_occ0: got %0d want 0", bb.occupancy); end
        drive_big(1'b1, e);
        @(negedge clk);
        drive_big(1'b0, '0);
        tests++; if (bb.out_valid !== 1'b1) begin fails++; $display("FAIL single_valid: got %b want 1", bb.out_valid); end
        tests++; if (big_out() !== e) begin fails++; $display("FAIL single_data: got %h want %h", big_out(), e); end
        tests++; if (bb.occupancy !== 2'd1) begin fails++; $display("FAIL single_occ1: got %0d want 1", bb.occupancy); end
        @(negedge clk);
        tests++; if (bb.occupancy !== 2'd0) begin fails++; $display("FAIL single_occ_end: got %0d want 0", bb.occupancy); end
        tests++; if (bb.out_valid !== 1'b0) begin fails++; $display("FAIL single_valid_end: got %b want 0", bb.out_valid); end
    endtask

    task automatic test_back_to_back();
        logic [BE-1:0] ex [8];
        bb.out_ready = 1'b1;
        for (int i = 0; i <= 8; i++) begin
            tests++; if (bb.in_ready !== 1'b1) begin fails++; $display("FAIL stream_in_ready[%0d]: got %b want 1", i, bb.in_ready); end
            if (i > 0) begin
                tests++; if (bb.out_valid !== 1'b1) begin fails++; $display("FAIL stream_valid[%0d]: got %b want 1", i, bb.out_valid); end
                tests++; if (big_out() !== ex[i-1]) begin fails++; $display("FAIL stream_data[%0d]: got %h want %h", i, big_out(), ex[i-1]); end
            end
            if (i < 8) begin
                ex[i] = rand_big();
                drive_big(1'b1, ex[i]);
            end else drive_big(1'b0, '0);
            @(negedge clk);
        end
        tests++; if (bb.out_valid !== 1'b0) begin fails++; $display("FAIL stream_drained: got %b want 0", bb.out_valid); end
    endtask

    task automatic test_skid();
        logic [BE-1:0] e0 = rand_big(), e1 = rand_big(), e2 = rand_big();
        bb.out_ready = 1'b0;
        drive_big(1'b1, e0);
        @(negedge clk);
        drive_big(1'b1, e1);
        @(negedge clk);
        drive_big(1'b1, e2);
        tests++; if (bb.occupancy !== 2'd2) begin fails++; $display("FAIL skid_occ2: got %0d want 2", bb.occupancy); end
        tests++; if (bb.in_ready !== 1'b0) begin fails++; $display("FAIL skid_in_ready_full: got %b want 0", bb.in_ready); end
        tests++; if (big_out() !== e0) begin fails++; $display("FAIL skid_first: got %h want %h", big_out(), e0); end
        bb.out_ready = 1'b1;
        @(negedge clk);
        tests++; if (big_out() !== e1) begin fails++; $display("FAIL skid_second: got %h want %h", big_out(), e1); end
        tests++; if (bb.in_ready !== 1'b1) begin fails++; $display("FAIL skid_in_ready_back: got %b want 1", bb.in_ready); end
        tests++; if (bb.occupancy !== 2'd1) begin fails++; $display("FAIL skid_occ1: got %0d want 1", bb.occupancy); end
        @(negedge clk);
        drive_big(1'b0, '0);
        tests++; if (big_out() !== e2 || bb.out_valid !== 1'b1) begin fails++; $display("FAIL skid_third: got %h want %h", big_out(), e2); end
        @(negedge clk);
        tests++; if (bb.occupancy !== 2'd0) begin fails++; $display("FAIL skid_empty: got %0d want 0", bb.occupancy); end
    endtask

    task automatic test_flush();
        bb.out_ready = 1'b0;
        drive_big(1'b1, rand_big());
        @(negedge clk);
        drive_big(1'b1, rand_big());
        @(negedge clk);
        tests++; if (bb.occupancy !== 2'd2) begin fails++; $display("FAIL flush_pre_occ: got %0d want 2", bb.occupancy); end
        bb.flush = 1'b1;
        drive_big(1'b1, rand_big());
        @(negedge clk);
        bb.flush = 1'b0;
        drive_big(1'b0, '0);
        tests++; if (bb.occupancy !== 2'd0) begin fails++; $display("FAIL flush_occ: got %0d want 0", bb.occupancy); end
        tests++; if (bb.out_valid !== 1'b0) begin fails++; $display("FAIL flush_valid: got %b want 0", bb.out_valid); end
        bb.out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            tests++; if (bb.out_valid !== 1'b0) begin fails++; $display("FAIL flush_ghost[%0d]: got %b want 0", i, bb.out_valid); end
        end
    endtask

    task automatic test_rst_mid();
        bb.out_ready = 1'b0;
        drive_big(1'b1, rand_big());
        @(negedge clk);
        drive_big(1'b1, rand_big());
        @(negedge clk);
        drive_big(1'b0, '0);
        tests++; if (bb.occupancy !== 2'd2) begin fails++; $display("FAIL rst_pre_occ: got %0d want 2", bb.occupancy); end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        tests++; if (bb.out_valid !== 1'b0) begin fails++; $display("FAIL rst_valid: got %b want 0", bb.out_valid); end
        tests++; if (bb.in_ready !== 1'b1) begin fails++; $display("FAIL rst_in_ready: got %b want 1", bb.in_ready); end
        tests++; if (bb.occupancy !== 2'd0) begin fails++; $display("FAIL rst_occ: got %0d want 0", bb.occupancy); end
        tests++; if (big_out() !== '0) begin fails++; $display("FAIL rst_data: got %h want 0", big_out()); end
        bb.out_ready = 1'b1;
        @(negedge clk);
        tests++; if (bb.out_valid !== 1'b0) begin fails++; $display("FAIL rst_ghost: got %b want 0", bb.out_valid); end
    endtask

    task automatic test_random();
        logic [SE-1:0] q [$];
        logic [SE-1:0] prev = '0, e;
        logic          stall = 1'b0, v, r, f;
        int            n;
        for (int c = 0; c < 10000; c++) begin
            n = q.size();
            tests++; if (sb.out_valid !== (n > 0)) begin fails++; $display("FAIL rnd_valid@%0d: got %b want %b", c, sb.out_valid, n > 0); end
            tests++; if (int'(sb.occupancy) !== n) begin fails++; $display("FAIL rnd_occ@%0d: got %0d want %0d", c, sb.occupancy, n); end
            tests++; if (sb.in_ready !== (n < 2)) begin fails++; $display("FAIL rnd_in_ready@%0d: got %b want %b", c, sb.in_ready, n < 2); end
            if (n > 0) begin
                tests++; if (small_out() !== q[0]) begin fails++; $display("FAIL rnd_data@%0d: got %h want %h", c, small_out(), q[0]); end
            end
            if (stall) begin
                tests++; if (small_out() !== prev) begin fails++; $display("FAIL rnd_stall@%0d: got %h want %h", c, small_out(), prev); end
            end
            v = $urandom_range(0, 3) != 0;
            r = $urandom_range(0, 2) != 0;
            f = $urandom_range(0, 199) == 0;
            e = {$urandom, $urandom};
            sb.in_valid = v;
            sb.out_ready = r;
            sb.flush = f;
            {sb.in_pp, sb.in_a, sb.in_b} = e;
            stall = (n > 0) && !r && !f;
            prev = small_out();
            if (f) q.delete();
            else begin
                if (n > 0 && r) void'(q.pop_front());
                if (v && n < 2) q.push_back(e);
            end
            @(negedge clk);
        end
        sb.in_valid = 1'b0;
    endtask

    initial begin
        bb.flush = 1'b0; bb.in_valid = 1'b0; bb.out_ready = 1'b0;
        bb.in_pp = '0; bb.in_a = '0; bb.in_b = '0;
        sb.flush = 1'b0; sb.in_valid = 1'b0; sb.out_ready = 1'b0;
        sb.in_pp = '0; sb.in_a = '0; sb.in_b = '0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        test_reset();
        rst = 1'b0;
        @(negedge clk);
        test_single();
        test_back_to_back();
        test_skid();
        test_flush();
        test_rst_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
